// File: rtl/dp_ram_pkg.sv
// Shared widths and arbiter state encoding for the dp_ram port arbiters.
package dp_ram_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    function automatic int dw_of(input int l2width);
        return 8 << l2width;
    endfunction

    function automatic int bw_of(input int l2width);
        return 1 << l2width;
    endfunction

    function automatic int aw_of(input int l2size, input int l2width);
        return l2size - l2width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set bit of valid at or above ptr, with wrap.
module rr_pick #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the search order backwards so the nearest requester is assigned last.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_ram_arb.sv
// Round-robin arbiter sharing one synchronous dp_ram port between NREQ requesters.
// Optional DP_RAM_ARB_CLEAR_EN adds a full-RAM zeroing sequence (clear_start/clear_done).
module dp_ram_arb
    import dp_ram_pkg::*;
#(
    parameter  int L2WIDTH = 3,
    parameter  int L2SIZE  = 14,
    parameter  int NREQ    = 3,
    localparam int DW      = dw_of(L2WIDTH),
    localparam int BW      = bw_of(L2WIDTH),
    localparam int AW      = aw_of(L2SIZE, L2WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wr_data,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*BW-1:0]   req_bwe,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rd_data,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wr_data,
    input  logic [DW-1:0]        ram_rd_data,
    output logic                 ram_enable,
    output logic                 ram_WE,
    output logic [BW-1:0]        ram_BWE
`ifdef DP_RAM_ARB_CLEAR_EN
   ,input  logic                 clear_start,
    output logic                 clear_done
`endif
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   lock_idx;
    logic            lock_vld;
    logic            lock_hit;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   ptr_nxt;
    logic            accept;

    rr_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A held lock only wins while its owner keeps asking; otherwise fall back to rotation.
    assign lock_hit = lock_vld & req_valid[lock_idx];
    assign gnt_idx  = lock_hit ? lock_idx : pick_idx;
    assign accept   = (state == ARB) & (lock_hit | pick_any);
    assign sel      = accept ? gnt_idx : rr_ptr;
    assign ptr_nxt  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        gnt_oh = pick_gnt;
        if (lock_hit) begin
            gnt_oh           = '0;
            gnt_oh[lock_idx] = 1'b1;
        end
    end

    assign req_ready   = accept ? gnt_oh : '0;
    assign rsp_rd_data = ram_rd_data;

`ifdef DP_RAM_ARB_CLEAR_EN
    logic          clr_start_q;
    logic [AW-1:0] clr_addr;
`endif

    always_comb begin
        ram_enable  = accept;
        ram_addr    = req_addr[sel*AW +: AW];
        ram_wr_data = req_wr_data[sel*DW +: DW];
        ram_WE      = req_we[sel];
        ram_BWE     = req_we[sel] ? req_bwe[sel*BW +: BW] : '0;
`ifdef DP_RAM_ARB_CLEAR_EN
        if (state == CLEAR) begin
            ram_enable  = 1'b1;
            ram_addr    = clr_addr;
            ram_wr_data = '0;
            ram_WE      = 1'b1;
            ram_BWE     = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            lock_vld  <= 1'b0;
            lock_idx  <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= (accept && !req_we[gnt_idx]) ? gnt_oh : '0;
            if (accept) begin
                rr_ptr   <= ptr_nxt;
                lock_vld <= req_lock[gnt_idx];
                lock_idx <= gnt_idx;
            end else if (lock_vld && !req_valid[lock_idx]) begin
                lock_vld <= 1'b0;
            end
        end
    end

`ifdef DP_RAM_ARB_CLEAR_EN
    // Clear sequencer: edge-triggered start, one word per cycle, done pulse after the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB;
            clr_addr    <= '0;
            clr_start_q <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            clr_start_q <= clear_start;
            clear_done  <= 1'b0;
            case (state)
                ARB: begin
                    if (clear_start && !clr_start_q) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state      <= ARB;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
`else
    assign state = ARB;
`endif

endmodule

// File: tb/tb_dp_ram_arb.sv
// Scoreboard bench for dp_ram_arb (default build): directed test-plan cases plus random traffic.
module tb_dp_ram_arb;

    localparam int NREQ = 3;
    localparam int AW   = 11;
    localparam int DW   = 64;
    localparam int BW   = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid, req_ready, req_lock, req_we, rsp_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wr_data;
    logic [NREQ*BW-1:0]  req_bwe;
    logic [DW-1:0]       rsp_rd_data, ram_wr_data, ram_rd_data;
    logic [AW-1:0]       ram_addr;
    logic                ram_enable, ram_WE;
    logic [BW-1:0]       ram_BWE;

    dp_ram_arb #(.L2WIDTH(3), .L2SIZE(14), .NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_we      (req_we),
        .req_bwe     (req_bwe),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .ram_enable  (ram_enable),
        .ram_WE      (ram_WE),
        .ram_BWE     (ram_BWE)
    );

    always #5 clk = ~clk;

    // Synchronous RAM port model, read-before-write, 1-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    assign ram_rd_data = ram_q;
    always @(posedge clk) begin
        if (ram_enable) begin
            ram_q <= ram[ram_addr];
            if (ram_WE)
                for (int b = 0; b < BW; b++)
                    if (ram_BWE[b]) ram[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: word memory as a sparse map, rotation pointer and lock owner as integers.
    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t          q[$];
    logic [63:0]   mref [int];
    int            m_ptr  = 0;
    int            m_lock = -1;

    function automatic logic [63:0] mem_rd(input int a);
        return mref.exists(a) ? mref[a] : 64'd0;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input bit we,
                           input int a, input logic [63:0] d, input logic [7:0] be);
        req_valid[i]              = v;
        req_lock[i]               = lk;
        req_we[i]                 = we;
        req_addr[i*AW +: AW]      = AW'(a);
        req_wr_data[i*DW +: DW]   = d;
        req_bwe[i*BW +: BW]       = be;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_lock  = '0;
        req_we    = '0;
    endtask

    // Compare the combinational accept against the model and post any expected response.
    task automatic eval(output int g);
        int          a;
        logic [63:0] nw;
        logic [7:0]  be;
        @(negedge clk);
        g = -1;
        if (m_lock >= 0 && req_valid[m_lock]) g = m_lock;
        else
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("ram_enable", 64'(ram_enable), (g < 0) ? 64'd0 : 64'd1);
        if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            chk("ram_addr", 64'(ram_addr), 64'(a));
            chk("ram_WE", 64'(ram_WE), 64'(req_we[g]));
            if (req_we[g]) begin
                be = req_bwe[g*BW +: BW];
                chk("ram_BWE", 64'(ram_BWE), 64'(be));
                chk("ram_wr_data", ram_wr_data, req_wr_data[g*DW +: DW]);
                nw = mem_rd(a);
                for (int b = 0; b < BW; b++)
                    if (be[b]) nw[b*8 +: 8] = req_wr_data[g*DW + b*8 +: 8];
                mref[a] = nw;
            end else begin
                chk("ram_BWE", 64'(ram_BWE), 64'd0);
                q.push_back('{g, mem_rd(a), cyc + 1});
            end
            m_ptr  = (g + 1) % NREQ;
            m_lock = req_lock[g] ? g : -1;
        end else if (m_lock >= 0 && !req_valid[m_lock]) begin
            m_lock = -1;
        end
    endtask

    // Monitor: any response pulse, or any overdue expectation, is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (rsp_valid != '0 || (q.size() > 0 && q[0].due <= cyc)) begin
                if (q.size() == 0) begin
                    chk("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.id);
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    if (rsp_valid != '0) chk("rsp_rd_data", rsp_rd_data, e.data);
                end
            end
        end
    end

    initial begin
        int g;
        logic [2:0] lk_exp [5];
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        reset       = 1'b0;
        req_addr    = '0;
        req_wr_data = '0;
        req_bwe     = '0;
        idle_inputs();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ram_enable", 64'(ram_enable), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        next_cyc();
        reset = 1'b1;

        // Strict rotation with all three continuously valid
        for (int k = 0; k < 6; k++) begin
            if (k != 0) next_cyc();
            for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, $urandom_range(0, 63), '0, '0);
            eval(g);
            chk("rot_grant", 64'(req_ready), 64'd1 << (k % 3));
        end
        next_cyc(); idle_inputs(); eval(g);

        // Pre-write then single read by req0
        next_cyc(); set_req(0, 1, 0, 1, 'h010, 64'h1122334455667788, 8'hFF); eval(g);
        next_cyc(); set_req(0, 1, 0, 0, 'h010, '0, '0); eval(g);
        next_cyc(); idle_inputs(); eval(g);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'b001);
        chk("rd_rsp_data", rsp_rd_data, 64'h1122334455667788);

        // Partial-byte write by req1, no response, then read back
        next_cyc(); set_req(1, 1, 0, 1, 'h020, 64'hAAAAAAAA_BBBBBBBB, 8'h0F); eval(g);
        next_cyc(); idle_inputs(); eval(g);
        chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        next_cyc(); set_req(1, 1, 0, 0, 'h020, '0, '0); eval(g);
        next_cyc(); idle_inputs(); eval(g);
        chk("bwe_rsp_data", rsp_rd_data, 64'h00000000_BBBBBBBB);

        // Burst lock by req2 for 4 accepts, then rotation resumes at req0
        lk_exp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        for (int k = 0; k < 5; k++) begin
            next_cyc();
            set_req(0, k != 0, 0, 0, 'h030, '0, '0);
            set_req(1, k != 0, 0, 0, 'h031, '0, '0);
            set_req(2, 1, k < 3, 0, 'h032 + k, '0, '0);
            eval(g);
            chk("lock_grant", 64'(req_ready), 64'(lk_exp[k]));
        end
        next_cyc(); idle_inputs(); eval(g);

        // Reset right after a locked read accept: response and lock are dropped, pointer back to 0
        next_cyc(); set_req(1, 1, 1, 0, 'h010, '0, '0); eval(g);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        m_ptr  = 0;
        m_lock = -1;
        idle_inputs();
        @(negedge clk);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        next_cyc(); next_cyc();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 'h010, '0, '0);
        eval(g);
        chk("ptr_after_rst", 64'(req_ready), 64'b001);
        next_cyc(); idle_inputs(); eval(g);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            next_cyc();
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 9) < 4, $urandom_range(0, 15),
                        {$urandom, $urandom}, 8'($urandom));
            eval(g);
        end
        next_cyc(); idle_inputs(); eval(g);
        next_cyc(); eval(g);
        next_cyc(); eval(g);
        chk("drain", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
